// File: rtl/tile_vram_arb_if.sv
// Tile RAM arbiter bus bundle: video fetch address, Z80 tile RAM port and the tile RAM itself.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface tile_vram_arb_if;
    logic [9:0] video_addr;
    logic       cpu_slot;
    logic       cpu_cs;
    logic       rdn;
    logic       wrn;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       waitn;
    logic [9:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       ram_ena;
    logic       ram_wr;
    logic [7:0] stall_cnt;

    modport slave (
        input  video_addr, cpu_slot, cpu_cs, rdn, wrn, cpu_addr, cpu_din, ram_dout,
        output cpu_dout, waitn, ram_addr, ram_din, ram_ena, ram_wr, stall_cnt
    );

    modport master (
        output video_addr, cpu_slot, cpu_cs, rdn, wrn, cpu_addr, cpu_din, ram_dout,
        input  cpu_dout, waitn, ram_addr, ram_din, ram_ena, ram_wr, stall_cnt
    );
endinterface

// File: rtl/tile_vram_arb.sv
// Shares the single-port tile RAM between video fetch (default owner) and the Z80, granting
// the CPU only in cpu_slot windows and stalling it through WAIT otherwise.
module tile_vram_arb #(
    parameter int unsigned RD_LAT = 1
) (
    input logic            clk,
    input logic            rst_n,
    tile_vram_arb_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPend, StRdWait, StDone} state_e;

    localparam logic [1:0] LatLast = 2'(RD_LAT);

    state_e     state_q;
    logic [1:0] lat_q;
    logic [7:0] cpu_dout_q;
    logic [7:0] stall_q;

    logic       req;
    logic       is_wr;
    logic       grant;
    logic [7:0] stall_sat;
    state_e     acc_next;

    assign req   = bus.cpu_cs & (~bus.rdn | ~bus.wrn);
    assign is_wr = ~bus.wrn;

    // The access cycle is the grant cycle itself, so it never lives in the state register.
    // Gating with rst_n keeps a held strobe from writing while reset is asserted.
    assign grant = rst_n & req & bus.cpu_slot & ((state_q == StIdle) | (state_q == StPend));

    assign acc_next  = is_wr ? StDone : StRdWait;
    assign stall_sat = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;

    assign bus.ram_addr  = grant ? bus.cpu_addr : bus.video_addr;
    assign bus.ram_ena   = 1'b1;
    assign bus.ram_wr    = grant & is_wr;
    assign bus.ram_din   = bus.cpu_din;
    assign bus.waitn     = ~(req & (state_q != StDone));
    assign bus.cpu_dout  = cpu_dout_q;
    assign bus.stall_cnt = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lat_q      <= 2'd0;
            cpu_dout_q <= 8'h00;
            stall_q    <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        // Counts the request cycle itself, which already has WAIT low.
                        stall_q <= 8'd1;
                        if (grant) begin
                            state_q <= acc_next;
                            lat_q   <= 2'd1;
                        end else begin
                            state_q <= StPend;
                        end
                    end
                end
                StPend: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end else begin
                        stall_q <= stall_sat;
                        if (grant) begin
                            state_q <= acc_next;
                            lat_q   <= 2'd1;
                        end
                    end
                end
                StRdWait: begin
                    if (req) begin
                        stall_q <= stall_sat;
                    end
                    if (lat_q == LatLast) begin
                        cpu_dout_q <= bus.ram_dout;
                        state_q    <= StDone;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                StDone: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_vram_arb.sv
// Directed bench for tile_vram_arb with a registered RD_LAT=1 tile RAM model.
module tb_tile_vram_arb;

    logic clk;
    logic rst_n;
    int   total;
    int   passes;
    int   fails;
    int   wr_pulses;
    int   pulses0;
    int   lowcnt;
    int   bad;

    logic [7:0] mem [1024];
    logic [7:0] rd_q;

    tile_vram_arb_if bus ();

    tile_vram_arb #(.RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wr) begin
                mem[bus.ram_addr] <= bus.ram_din;
                wr_pulses         <= wr_pulses + 1;
            end
            rd_q <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_dout = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cpu_cs = 1'b0;
        bus.rdn    = 1'b1;
        bus.wrn    = 1'b1;
    endtask

    task automatic cpu_req(input logic wr, input logic [9:0] a, input logic [7:0] d);
        bus.cpu_cs   = 1'b1;
        bus.rdn      = wr;
        bus.wrn      = ~wr;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        total = 0; passes = 0; fails = 0; wr_pulses = 0;
        idle_bus();
        bus.cpu_addr = 10'h000; bus.cpu_din = 8'h00;
        bus.video_addr = 10'h012; bus.cpu_slot = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_cpu_dout", bus.cpu_dout, 8'h00);
        check("rst_stall", bus.stall_cnt, 8'h00);
        check("rst_ram_wr", bus.ram_wr, 1'b0);
        check("rst_ram_ena", bus.ram_ena, 1'b1);
        check("rst_ram_addr", bus.ram_addr, 10'h012);
        check("rst_waitn", bus.waitn, 1'b1);
        @(negedge clk); rst_n = 1'b1;

        // Load RAM[0x3FF]=0x5C through the arbiter
        @(negedge clk);
        cpu_req(1'b1, 10'h3FF, 8'h5C); bus.cpu_slot = 1'b1; #1;
        check("pre_ram_wr", bus.ram_wr, 1'b1);
        @(negedge clk); idle_bus();
        @(negedge clk);

        // Write 0x155=0xA5 in a slot, then hold the strobe 10 cycles
        bus.video_addr = 10'h020;
        cpu_req(1'b1, 10'h155, 8'hA5); #1;
        pulses0 = wr_pulses;
        check("wr_ram_wr", bus.ram_wr, 1'b1);
        check("wr_ram_addr", bus.ram_addr, 10'h155);
        check("wr_ram_din", bus.ram_din, 8'hA5);
        check("wr_waitn_low", bus.waitn, 1'b0);
        lowcnt = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!bus.waitn) lowcnt++;
            if (bus.ram_wr) bad++;
        end
        check("wr_done_waitn_low_cycles", lowcnt, 0);
        check("wr_done_ram_wr_cycles", bad, 0);
        check("wr_stall", bus.stall_cnt, 8'd1);
        check("wr_ram_addr_video", bus.ram_addr, 10'h020);
        idle_bus();
        @(negedge clk); #1;
        check("wr_single_pulse", wr_pulses - pulses0, 1);

        // Read back 0x155
        cpu_req(1'b0, 10'h155, 8'h00); #1;
        check("rd_waitn_acc", bus.waitn, 1'b0);
        check("rd_addr_acc", bus.ram_addr, 10'h155);
        check("rd_no_wr", bus.ram_wr, 1'b0);
        @(negedge clk); #1;
        check("rd_waitn_rdwait", bus.waitn, 1'b0);
        check("rd_addr_rdwait", bus.ram_addr, 10'h020);
        @(negedge clk); #1;
        check("rd_dout", bus.cpu_dout, 8'hA5);
        check("rd_waitn_done", bus.waitn, 1'b1);
        check("rd_stall", bus.stall_cnt, 8'd2);
        idle_bus();
        @(negedge clk);

        // Read 0x3FF stalled 20 cycles, then granted
        cpu_req(1'b0, 10'h3FF, 8'h00);
        lowcnt = 0; bad = 0;
        for (int c = 0; c < 25; c++) begin
            bus.cpu_slot   = (c >= 20);
            bus.video_addr = 10'(c * 37 + 5);
            #1;
            if (!bus.waitn) lowcnt++;
            if (c < 20 && bus.ram_addr !== bus.video_addr) bad++;
            if (c == 20 && bus.ram_addr !== 10'h3FF) bad++;
            @(negedge clk);
        end
        #1;
        check("pend_waitn_low_cycles", lowcnt, 22);
        check("pend_addr_tracking", bad, 0);
        check("pend_cpu_dout", bus.cpu_dout, 8'h5C);
        check("pend_stall", bus.stall_cnt, 8'd22);
        idle_bus();
        @(negedge clk);

        // Stall over 300 cycles saturates; rdn & wrn both low is a write
        bus.cpu_slot = 1'b0;
        bus.cpu_cs = 1'b1; bus.rdn = 1'b0; bus.wrn = 1'b0;
        bus.cpu_addr = 10'h0AA; bus.cpu_din = 8'h3C;
        repeat (300) @(negedge clk);
        #1;
        check("sat_stall", bus.stall_cnt, 8'd255);
        check("sat_waitn", bus.waitn, 1'b0);
        bus.cpu_slot = 1'b1; #1;
        check("sat_ram_wr", bus.ram_wr, 1'b1);
        check("sat_ram_addr", bus.ram_addr, 10'h0AA);
        @(negedge clk); #1;
        check("sat_done_waitn", bus.waitn, 1'b1);
        check("sat_done_stall", bus.stall_cnt, 8'd255);
        check("sat_mem", mem[10'h0AA], 8'h3C);
        check("sat_dout_kept", bus.cpu_dout, 8'h5C);
        idle_bus();
        @(negedge clk);

        // Write aborted during PEND
        pulses0 = wr_pulses;
        bus.cpu_slot = 1'b0;
        cpu_req(1'b1, 10'h111, 8'hEE);
        repeat (5) @(negedge clk);
        idle_bus(); bus.cpu_slot = 1'b1; #1;
        check("ab_waitn", bus.waitn, 1'b1);
        check("ab_ram_wr", bus.ram_wr, 1'b0);
        @(negedge clk); #1;
        check("ab_no_write", wr_pulses - pulses0, 0);
        check("ab_dout", bus.cpu_dout, 8'h5C);
        check("ab_stall", bus.stall_cnt, 8'd5);
        check("ab_addr_video", bus.ram_addr, bus.video_addr);

        // Reset pulse during RDWAIT, released with req low
        cpu_req(1'b0, 10'h155, 8'h00);
        @(negedge clk);
        rst_n = 1'b0; idle_bus(); #1;
        check("rs_dout", bus.cpu_dout, 8'h00);
        check("rs_stall", bus.stall_cnt, 8'h00);
        check("rs_ram_wr", bus.ram_wr, 1'b0);
        check("rs_waitn", bus.waitn, 1'b1);
        check("rs_addr", bus.ram_addr, bus.video_addr);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.video_addr = 10'(10'h2A0 + i * 11); #1;
            if (bus.ram_addr !== bus.video_addr || bus.waitn !== 1'b1 ||
                bus.ram_wr !== 1'b0 || bus.cpu_dout !== 8'h00) bad++;
        end
        check("rs_idle_tracking", bad, 0);

        // Held write strobe across reset: nothing during reset, new access after release
        @(negedge clk);
        rst_n = 1'b0; cpu_req(1'b1, 10'h077, 8'h99); bus.cpu_slot = 1'b1; #1;
        check("rs_wr_gated", bus.ram_wr, 1'b0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("rs_rel_wr", bus.ram_wr, 1'b1);
        check("rs_rel_addr", bus.ram_addr, 10'h077);
        @(negedge clk); #1;
        check("rs_rel_done_waitn", bus.waitn, 1'b1);
        check("rs_rel_mem", mem[10'h077], 8'h99);
        idle_bus();
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
